// File: rtl/kmac_pkg.sv
// Shared types and default widths for the Karatsuba MAC accumulator.
// The KMAC_SATURATE_EN option is selected inside karatsuba_mac_accumulator.
package kmac_pkg;

  localparam int KMAC_PROD_W = 32;
  localparam int KMAC_ACC_W  = 40;
  localparam int KMAC_CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } kmac_state_t;

endpackage

// File: rtl/rca_Nbit.sv
// N-bit ripple-carry adder used for the accumulator add.
// Carry-out is exposed so the caller can detect overflow.
module rca_Nbit #(
  parameter int N = 40
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic carry;

  // NOTE: blocking '=' is correct here; the carry must ripple through the loop
  // within one evaluation, and every output is assigned before it is read.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/karatsuba_mac_accumulator.sv
// Accumulates multiplier products into one dot-product result per in_last-delimited group.
// Define KMAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module karatsuba_mac_accumulator
  import kmac_pkg::*;
#(
  parameter int PROD_W = KMAC_PROD_W,
  parameter int ACC_W  = KMAC_ACC_W,
  parameter int CNT_W  = KMAC_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  kmac_state_t      state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  rca_Nbit #(.N(ACC_W)) u_add (
    .a    (acc),
    .b    (ACC_W'(in_prod)),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_carry)
  );

`ifdef KMAC_SATURATE_EN
  // Once clamped to all-ones, any further non-zero product carries again, so it stays clamped.
  assign acc_next = add_carry ? '1 : add_sum;
`else
  assign acc_next = add_sum;
`endif

  assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign in_ready = (state == ACCUM);

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              out_acc   <= acc_next;
              out_count <= cnt_next;
              out_ovf   <= ovf | add_carry;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= DRAIN;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
              ovf <= ovf | add_carry;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mac_accumulator.sv
// Self-checking bench for karatsuba_mac_accumulator against an arithmetic group-sum model.
// Expectations follow KMAC_SATURATE_EN when the bench is compiled with it.
module tb_karatsuba_mac_accumulator;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;
  localparam logic [63:0] ACC_LIM = 64'd1 << ACC_W;
  localparam int BUDGET = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  karatsuba_mac_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] acc;
    logic [63:0] cnt;
    logic        ovf;
  } res_t;

  // Reference model: exact group sum in wide arithmetic, reduced only when the group closes.
  logic [63:0] g_sum;
  int          g_n;
  res_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic res_t model_close(input logic [63:0] s, input int n);
    res_t r;
    r.ovf = (s >= ACC_LIM);
`ifdef KMAC_SATURATE_EN
    r.acc = r.ovf ? ACC_LIM - 64'd1 : s;
`else
    r.acc = s % ACC_LIM;
`endif
    r.cnt = (n > 255) ? 64'd255 : 64'(n);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    g_sum = 0;
    g_n = 0;
    exp_q.delete();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [31:0] p, input logic last);
    int b = 0;
    in_valid = 1'b1;
    in_prod = p;
    in_last = last;
    while (!in_ready && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    g_sum += 64'(p);
    g_n++;
    if (last) begin
      exp_q.push_back(model_close(g_sum, g_n));
      g_sum = 0;
      g_n = 0;
    end
  endtask

  task automatic expect_result(input string tag, input int hold);
    int   b = 0;
    res_t e;
    while (!out_valid && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_valid"}, out_valid, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'(exp_q.size()), 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_acc"}, out_acc, e.acc);
    check({tag, "_count"}, out_count, e.cnt);
    check({tag, "_ovf"}, out_ovf, e.ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_acc"}, out_acc, e.acc);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_acc_kept"}, out_acc, e.acc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    g_sum = 0;
    g_n = 0;
    @(negedge clk);

    // Reset state.
    do_reset();

    // Simple group; result must be visible right after the last beat.
    send_beat(32'd6, 1'b0);
    send_beat(32'd15, 1'b0);
    send_beat(32'd100, 1'b1);
    check("latency_valid", out_valid, 1);
    check("latency_in_ready", in_ready, 0);
    expect_result("grp3", 0);

    // Same group with backpressure for five cycles.
    send_beat(32'd6, 1'b0);
    send_beat(32'd15, 1'b0);
    send_beat(32'd100, 1'b1);
    expect_result("grp3_bp", 5);

    // Counter saturation and overflow.
    for (int i = 0; i < 257; i++) send_beat(32'hFFFF_FFFF, i == 256);
    expect_result("grp257", 1);

    // Reset mid-group discards the partial sum.
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b0);
    do_reset();
    send_beat(32'd7, 1'b1);
    expect_result("post_rst", 0);

    // Reset while a result is pending discards it.
    send_beat(32'd9, 1'b1);
    do_reset();
    check("rst_drain_valid", out_valid, 0);

    // Back-to-back groups: no carry leakage.
    send_beat(32'hFFFF_FFFF, 1'b1);
    expect_result("b2b_a", 0);
    send_beat(32'd1, 1'b1);
    expect_result("b2b_b", 0);

    // Randomized groups with idle gaps and backpressure.
    for (int g = 0; g < 16; g++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat($urandom, k == n - 1);
      end
      expect_result("rand", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
